// File: rtl/pong_pkg.sv
// Shared definitions for the pong datapath.
//   state_t        : game sequencer state encoding (3 bits, visible on the state port)
//   WINNER_*       : encodings for the winner output
//   DEF_*          : default game parameters
//   playfield      : geometry constants shared with the ball and paddle blocks
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_POINT     = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    localparam int DEF_WIN_SCORE    = 9;
    localparam int DEF_SCORE_W      = 4;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_CNT_W        = 6;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int BALL_SIZE = 8;
    localparam int PADDLE_W  = 8;
    localparam int PADDLE_H  = 64;

endpackage

// File: rtl/pong_game_ctrl_score_counter.sv
// Saturating score counter.
//   clk   : system clock
//   reset : asynchronous active-low reset, clears the count
//   clr   : synchronous clear (wins over inc)
//   inc   : synchronous increment, holds at all-ones
//   count : current score
module score_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] COUNT_MAX = '1;

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != COUNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve delay, per-frame ball stepping, scoring, winner.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   frame_tick : one-cycle pulse per video frame
//   start      : debounced start/pause button (level)
//   point_1/2  : point events from the ball block
//   ball_rst   : holds ball at serve position (low only in PLAY and PAUSE)
//   ball_en    : one-cycle ball step enable
//   serve_dir  : initial ball x direction, 1 = +x
//   score_1/2  : player scores
//   winner     : 00 none, 01 player 1, 10 player 2
//   state      : current state code
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SCORE_W      = DEF_SCORE_W,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               point_1,
    input  logic               point_2,
    output logic               ball_rst,
    output logic               ball_en,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    state_t             state_reg, state_next;
    logic               start_q_reg;
    logic               start_evt;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ball_rst_reg, ball_rst_next;
    logic               ball_en_reg, ball_en_next;
    logic               serve_dir_reg, serve_dir_next;
    logic [1:0]         winner_reg, winner_next;
    // Which player the pending POINT credits: 1 = player 1, 0 = player 2.
    logic               credit_p1_reg, credit_p1_next;
    logic               clr_scores;
    logic [1:0]         inc_vec;
    logic [SCORE_W-1:0] score_arr [2];
    logic [SCORE_W-1:0] credited, credited_new;

    assign start_evt    = start & ~start_q_reg;
    assign credited     = credit_p1_reg ? score_arr[0] : score_arr[1];
    assign credited_new = (credited == SCORE_MAX) ? credited : credited + 1'b1;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = '0;
        serve_dir_next = serve_dir_reg;
        winner_next    = winner_reg;
        credit_p1_next = credit_p1_reg;
        clr_scores     = 1'b0;
        inc_vec        = 2'b00;
        case (state_reg)
            ST_IDLE: begin
                if (start_evt) begin
                    clr_scores  = 1'b1;
                    winner_next = WINNER_NONE;
                    state_next  = ST_SERVE;
                end
            end
            ST_SERVE: begin
                cnt_next = cnt_reg;
                if (frame_tick) begin
                    if (cnt_reg == SERVE_LAST) begin
                        cnt_next   = '0;
                        state_next = ST_PLAY;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                // Point 1 beats point 2; any point beats a pause request.
                if (point_1) begin
                    credit_p1_next = 1'b1;
                    state_next     = ST_POINT;
                end else if (point_2) begin
                    credit_p1_next = 1'b0;
                    state_next     = ST_POINT;
                end else if (start_evt) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (start_evt) begin
                    state_next = ST_PLAY;
                end
            end
            ST_POINT: begin
                inc_vec        = credit_p1_reg ? 2'b01 : 2'b10;
                serve_dir_next = credit_p1_reg;
                if (credited_new == WIN_VAL) begin
                    winner_next = credit_p1_reg ? WINNER_P1 : WINNER_P2;
                    state_next  = ST_GAME_OVER;
                end else begin
                    state_next = ST_SERVE;
                end
            end
            ST_GAME_OVER: begin
                if (start_evt) begin
                    clr_scores     = 1'b1;
                    winner_next    = WINNER_NONE;
                    serve_dir_next = 1'b1;
                    state_next     = ST_SERVE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so they line up
    // with the state they belong to. A tick that also changes state (serve
    // release, point, pause) does not step the ball.
    always_comb begin
        ball_en_next  = frame_tick && (state_reg == ST_PLAY) && (state_next == ST_PLAY);
        ball_rst_next = !((state_next == ST_PLAY) || (state_next == ST_PAUSE));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            start_q_reg   <= 1'b0;
            cnt_reg       <= '0;
            ball_rst_reg  <= 1'b1;
            ball_en_reg   <= 1'b0;
            serve_dir_reg <= 1'b1;
            winner_reg    <= WINNER_NONE;
            credit_p1_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            start_q_reg   <= start;
            cnt_reg       <= cnt_next;
            ball_rst_reg  <= ball_rst_next;
            ball_en_reg   <= ball_en_next;
            serve_dir_reg <= serve_dir_next;
            winner_reg    <= winner_next;
            credit_p1_reg <= credit_p1_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_score
            score_counter #(
                .W(SCORE_W)
            ) u_score (
                .clk   (clk),
                .reset (reset),
                .clr   (clr_scores),
                .inc   (inc_vec[gi]),
                .count (score_arr[gi])
            );
        end
    endgenerate

    assign score_1   = score_arr[0];
    assign score_2   = score_arr[1];
    assign ball_rst  = ball_rst_reg;
    assign ball_en   = ball_en_reg;
    assign serve_dir = serve_dir_reg;
    assign winner    = winner_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

    localparam int WIN = 9;
    localparam int SW  = 4;
    localparam int SF  = 60;
    localparam int CW  = 6;
    localparam int SMAX = (1 << SW) - 1;

    // Game phases as named in the state code table.
    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_PAUSE = 3, M_POINT = 4, M_OVER = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic          start = 1'b0;
    logic          point_1 = 1'b0;
    logic          point_2 = 1'b0;
    logic          ball_rst, ball_en, serve_dir;
    logic [SW-1:0] score_1, score_2;
    logic [1:0]    winner;
    logic [2:0]    state;

    pong_game_ctrl #(
        .WIN_SCORE    (WIN),
        .SCORE_W      (SW),
        .SERVE_FRAMES (SF),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .point_1    (point_1),
        .point_2    (point_2),
        .ball_rst   (ball_rst),
        .ball_en    (ball_en),
        .serve_dir  (serve_dir),
        .score_1    (score_1),
        .score_2    (score_2),
        .winner     (winner),
        .state      (state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference game: what the players would see after each clock.
    int m_st, m_s1, m_s2, m_win, m_frames, m_credit;
    bit m_dir, m_en, m_prev_start;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] obs_vec();
        return {state, ball_rst, ball_en, serve_dir, score_1, score_2, winner};
    endfunction

    function automatic logic [16:0] exp_vec();
        bit frozen_or_moving;
        frozen_or_moving = (m_st == M_PLAY) || (m_st == M_PAUSE);
        return {3'(m_st), !frozen_or_moving, m_en, m_dir, 4'(m_s1), 4'(m_s2), 2'(m_win)};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; m_frames = 0;
        m_credit = 1; m_dir = 1'b1; m_en = 1'b0; m_prev_start = 1'b0;
    endtask

    task automatic model_step();
        bit evt;
        int s;
        evt = start && !m_prev_start;
        m_prev_start = start;
        m_en = 1'b0;
        if (m_st == M_IDLE) begin
            if (evt) begin m_s1 = 0; m_s2 = 0; m_win = 0; m_frames = 0; m_st = M_SERVE; end
        end else if (m_st == M_SERVE) begin
            if (frame_tick) begin
                m_frames++;
                if (m_frames == SF) begin m_frames = 0; m_st = M_PLAY; end
            end
        end else if (m_st == M_PLAY) begin
            if (point_1)         begin m_credit = 1; m_st = M_POINT; end
            else if (point_2)    begin m_credit = 2; m_st = M_POINT; end
            else if (evt)        m_st = M_PAUSE;
            else if (frame_tick) m_en = 1'b1;
        end else if (m_st == M_PAUSE) begin
            if (evt) m_st = M_PLAY;
        end else if (m_st == M_POINT) begin
            if (m_credit == 1) begin
                m_s1 = (m_s1 < SMAX) ? m_s1 + 1 : SMAX; s = m_s1; m_dir = 1'b1;
            end else begin
                m_s2 = (m_s2 < SMAX) ? m_s2 + 1 : SMAX; s = m_s2; m_dir = 1'b0;
            end
            if (s == WIN) begin m_win = m_credit; m_st = M_OVER; end
            else begin m_frames = 0; m_st = M_SERVE; end
        end else if (m_st == M_OVER) begin
            if (evt) begin
                m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 1'b1; m_frames = 0; m_st = M_SERVE;
            end
        end
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then compare on the falling edge.
    task automatic cyc();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_step();
        @(negedge clk);
        check("cycle", 32'(obs_vec()), 32'(exp_vec()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 2));
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
        end
    endtask

    task automatic press(input int hold);
        start = 1'b1;
        idle(hold);
        start = 1'b0;
        cyc();
    endtask

    task automatic score(input bit a, input bit b, input int hold);
        point_1 = a;
        point_2 = b;
        idle(hold);
        point_1 = 1'b0;
        point_2 = 1'b0;
        cyc();
    endtask

    initial begin
        int guard;
        model_reset();
        // Reset state before any clock edge.
        #1 reset = 1'b0;
        #1;
        check("reset_vals", 32'(obs_vec()), 32'(exp_vec()));
        idle(3);
        reset = 1'b1;
        idle(2);

        // Serve delay then play.
        press(1);
        check("serve_entered", 32'(state), M_SERVE);
        ticks(SF);
        check("play_after_serve", 32'(state), M_PLAY);
        check("ball_rst_released", 32'(ball_rst), 0);
        ticks(5);

        // Held point counted once.
        score(1'b1, 1'b0, 3);
        check("p1_held_once", 32'(score_1), 1);
        ticks(SF + 3);

        // Simultaneous points: player 1 wins the tie.
        score(1'b1, 1'b1, 1);
        check("tie_p1", 32'(score_1), 2);
        check("tie_p2", 32'(score_2), 0);
        ticks(SF + 2);

        // Point coinciding with a start edge: the point wins.
        start = 1'b1;
        point_2 = 1'b1;
        cyc();
        start = 1'b0;
        point_2 = 1'b0;
        cyc();
        check("point_over_pause", 32'(score_2), 1);
        ticks(SF + 2);

        // Pause and resume with a held button.
        press($urandom_range(1, 4));
        check("paused", 32'(state), M_PAUSE);
        ticks(5);
        press($urandom_range(1, 4));
        check("resumed", 32'(state), M_PLAY);
        ticks(4);

        // Player 2 runs the game out.
        guard = 0;
        while (m_win == 0 && guard < 20) begin
            ticks($urandom_range(1, 4));
            score(1'b0, 1'b1, $urandom_range(1, 3));
            if (m_win == 0) ticks(SF);
            guard++;
        end
        check("winner_p2", 32'(winner), 2);
        check("game_over", 32'(state), M_OVER);
        check("score2_win", 32'(score_2), WIN);
        score(1'b0, 1'b1, 2);
        ticks(2);
        check("held_after_win", 32'(score_2), WIN);
        press(1);
        check("restart_scores", 32'({score_1, score_2}), 0);
        check("restart_winner", 32'(winner), 0);

        // Bring player 1 to four, then reset asynchronously mid-serve.
        for (int k = 0; k < 4; k++) begin
            ticks(SF);
            ticks($urandom_range(0, 3));
            score(1'b1, 1'b0, 1);
        end
        ticks(3);
        check("score1_four", 32'(score_1), 4);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("async_reset", 32'(obs_vec()), 32'(exp_vec()));
        idle(2);
        reset = 1'b1;
        idle(2);
        press(1);
        ticks(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
